fp32_divider: RTL and testbench

//  Sequential IEEE-754 single-precision divider, the inverse companion of the combinational FP multiplier.

---
 rtl/fp32_pkg.sv | 22 ++
 rtl/fp32_divider_if.sv | 18 +
 rtl/fp_mant_divider.sv | 44 ++++
 rtl/fp32_divider.sv | 168 ++++++++++++++++
 tb/tb_fp32_divider.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared constants and FSM encoding for the sequential fp32 divider.
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int SIG_W = MAN_W + 1;   // significand with hidden bit
  localparam int QW    = MAN_W + 3;   // quotient bits produced by the core
  localparam int EXP_X = EXP_W + 2;   // signed working exponent width

  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [31:0]      POS_INF = 32'h7F800000;
  localparam logic [EXP_X-1:0] E_BIAS  = EXP_X'(BIAS);
  localparam logic [EXP_X-1:0] E_INF   = EXP_X'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_FIN} state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;
endpackage

// File: rtl/fp32_divider_if.sv
// Start/done handshake bundle between the host and the fp32 divider.
interface fp32_divider_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic        div_by_zero;
  logic        invalid;
  logic        overflow;
  logic        underflow;

  modport master (output start, a, b,
                  input  busy, done, quotient, div_by_zero, invalid, overflow, underflow);
  modport slave  (input  start, a, b,
                  output busy, done, quotient, div_by_zero, invalid, overflow, underflow);
endinterface

// File: rtl/fp_mant_divider.sv
// Restoring significand divider: load performs the first iteration on ma,
// each step shifts the remainder and retires one more quotient bit.
module fp_mant_divider
  import fp32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [SIG_W-1:0] ma,
  input  logic [SIG_W-1:0] mb,
  output logic [QW-1:0]    q,
  output logic             rem_nz
);
  logic [SIG_W-1:0] r_rem;
  logic [SIG_W-1:0] r_mb;
  logic [QW-1:0]    r_q;
  logic [SIG_W:0]   w_trial;
  logic [SIG_W:0]   w_div;
  logic [SIG_W:0]   w_diff;
  logic             w_ge;

  // Remainder stays below the divisor, so it fits in SIG_W bits between steps.
  assign w_trial = load ? {1'b0, ma} : {r_rem, 1'b0};
  assign w_div   = load ? {1'b0, mb} : {1'b0, r_mb};
  assign w_diff  = w_trial - w_div;
  assign w_ge    = (w_trial >= w_div);

  // One restoring iteration per load/step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_mb  <= '0;
      r_q   <= '0;
    end else if (load || step) begin
      r_rem <= w_ge ? w_diff[SIG_W-1:0] : w_trial[SIG_W-1:0];
      r_q   <= load ? {{(QW-1){1'b0}}, w_ge} : {r_q[QW-2:0], w_ge};
      if (load) r_mb <= mb;
    end
  end

  assign q      = r_q;
  assign rem_nz = |r_rem;
endmodule

// File: rtl/fp32_divider.sv
// Sequential IEEE-754 single-precision divider (a / b), start/done handshake.
// Build option: FP_DIV_ROUND_EN selects round-to-nearest-even; otherwise truncate.
module fp32_divider
  import fp32_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fp32_divider_if.slave  bus
);
  fp32_t            w_a, w_b;
  logic             w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic             w_sign, w_accept, w_spec;
  logic [31:0]      w_spec_res;
  logic [3:0]       w_spec_flg;            // {div_by_zero, invalid, overflow, underflow}
  logic [EXP_X-1:0] w_e0, w_exp_f;
  logic [QW-1:0]    w_q;
  logic             w_rem_nz, w_inc, w_ovf, w_unf;
  logic [MAN_W:0]   w_man_r;

  state_t           r_state;
  logic [4:0]       r_cnt;
  logic             r_sign, r_spec, r_busy, r_done;
  logic [EXP_X-1:0] r_exp;
  logic [MAN_W-1:0] r_man;
  logic [31:0]      r_spec_res, r_quot;
  logic [3:0]       r_spec_flg, r_flg;

  assign w_a      = bus.a;
  assign w_b      = bus.b;
  assign w_a_zero = (w_a.exp == '0);
  assign w_b_zero = (w_b.exp == '0);
  assign w_a_inf  = (&w_a.exp) && (w_a.man == '0);
  assign w_b_inf  = (&w_b.exp) && (w_b.man == '0);
  assign w_a_nan  = (&w_a.exp) && (w_a.man != '0);
  assign w_b_nan  = (&w_b.exp) && (w_b.man != '0);
  assign w_sign   = w_a.sign ^ w_b.sign;
  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_e0     = {2'b00, w_a.exp} - {2'b00, w_b.exp} + E_BIAS;

  // Operands that never need the divider resolve at start.
  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = '0;
    w_spec_flg = '0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res = QNAN;
      w_spec_flg = 4'b0100;
    end else if (w_b_zero) begin
      w_spec_res = {w_sign, POS_INF[30:0]};
      w_spec_flg = {~w_a_inf, 3'b000};   // inf/0 is plain inf, not a divide-by-zero
    end else if (w_a_inf) begin
      w_spec_res = {w_sign, POS_INF[30:0]};
    end else if (w_a_zero || w_b_inf) begin
      w_spec_res = {w_sign, 31'b0};
    end else begin
      w_spec = 1'b0;
    end
  end

  fp_mant_divider u_mant (
    .clk    (clk),
    .rst    (rst),
    .load   (w_accept),
    .step   (r_state == S_DIV),
    .ma     ({1'b1, w_a.man}),
    .mb     ({1'b1, w_b.man}),
    .q      (w_q),
    .rem_nz (w_rem_nz)
  );

`ifdef FP_DIV_ROUND_EN
  logic r_grd, r_stk;
  assign w_inc = r_grd & (r_stk | r_man[0]);

  // Guard/sticky capture alongside normalization.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grd <= 1'b0;
      r_stk <= 1'b0;
    end else if (r_state == S_NORM) begin
      r_grd <= w_q[QW-1] ? w_q[1] : w_q[0];
      r_stk <= (w_q[QW-1] & w_q[0]) | w_rem_nz;
    end
  end
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^{w_q[1:0], w_rem_nz};
  assign w_inc        = 1'b0;
`endif

  // Rounding carry-out bumps the exponent; the wrapped mantissa is already zero.
  assign w_man_r = {1'b0, r_man} + {{MAN_W{1'b0}}, w_inc};
  assign w_exp_f = r_exp + {{(EXP_X-1){1'b0}}, w_man_r[MAN_W]};
  assign w_unf   = w_exp_f[EXP_X-1] || (w_exp_f == '0);
  assign w_ovf   = !w_exp_f[EXP_X-1] && (w_exp_f >= E_INF);

  // Control FSM with registered handshake outputs and result packing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_spec     <= 1'b0;
      r_exp      <= '0;
      r_man      <= '0;
      r_spec_res <= '0;
      r_spec_flg <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_flg      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_busy     <= 1'b1;
          r_flg      <= '0;
          r_sign     <= w_sign;
          r_exp      <= w_e0;
          r_spec     <= w_spec;
          r_spec_res <= w_spec_res;
          r_spec_flg <= w_spec_flg;
          r_cnt      <= 5'(QW - 2);       // load already did the first iteration
          r_state    <= w_spec ? S_FIN : S_DIV;
        end
        S_DIV: begin
          if (r_cnt == '0) r_state <= S_NORM;
          else             r_cnt   <= r_cnt - 5'd1;
        end
        S_NORM: begin
          if (w_q[QW-1]) begin
            r_man <= w_q[QW-2:2];
          end else begin
            r_man <= w_q[QW-3:1];
            r_exp <= r_exp - {{(EXP_X-1){1'b0}}, 1'b1};
          end
          r_state <= S_FIN;
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
          if (r_spec) begin
            r_quot <= r_spec_res;
            r_flg  <= r_spec_flg;
          end else if (w_ovf) begin
            r_quot <= {r_sign, POS_INF[30:0]};
            r_flg  <= 4'b0010;
          end else if (w_unf) begin
            r_quot <= {r_sign, 31'b0};
            r_flg  <= 4'b0001;
          end else begin
            r_quot <= {r_sign, w_exp_f[EXP_W-1:0], w_man_r[MAN_W-1:0]};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.div_by_zero = r_flg[3];
  assign bus.invalid     = r_flg[2];
  assign bus.overflow    = r_flg[1];
  assign bus.underflow   = r_flg[0];
endmodule

// File: tb/tb_fp32_divider.sv
// Self-checking bench for fp32_divider: vector table + scoreboard queue,
// plus hand-written busy-ignore, flag-clear and mid-operation reset sequences.
module tb_fp32_divider;
  import fp32_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [3:0]  f;    // {div_by_zero, invalid, overflow, underflow}
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  f;
    int          lat;
  } exp_t;

`ifdef FP_DIV_ROUND_EN
  localparam logic [31:0] Q_THIRD = 32'h3EAAAAAB;
  localparam logic [31:0] Q_NEAR1 = 32'h3F800001;
`else
  localparam logic [31:0] Q_THIRD = 32'h3EAAAAAA;
  localparam logic [31:0] Q_NEAR1 = 32'h3F800000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp32_divider_if bus ();
  fp32_divider dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  vec_t tv[16];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [3:0] flags();
    return {bus.div_by_zero, bus.invalid, bus.overflow, bus.underflow};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Issue one operation; optionally pulse a stray start at cycle poke_at.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                        input logic [3:0] f, input int lat, input int poke_at, input string nm);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    e.q = q; e.f = f; e.lat = lat;
    sb.push_back(e);
    n = 0; seen = 0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      bus.start = (poke_at > 0 && n == poke_at);
      bus.a = (n == poke_at) ? 32'h3F800000 : $urandom;
      bus.b = (n == poke_at) ? 32'h00000000 : $urandom;
      if (n == 1) begin
        chk({nm, " busy@1"}, 32'(bus.busy), 32'd1);
        chk({nm, " flags cleared@1"}, 32'(flags()), 32'd0);
      end
      if (bus.done) begin
        seen = 1;
        e = sb.pop_front();
        chk({nm, " latency"}, 32'(n), 32'(e.lat));
        chk({nm, " quotient"}, bus.quotient, e.q);
        chk({nm, " flags"}, 32'(flags()), 32'(e.f));
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL %s done timeout: no done within %0d cycles, expected at %0d", nm, n, lat);
      sb.delete();
    end else begin
      @(negedge clk);
      chk({nm, " done pulse width"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    bit saw;

    tv[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28};
    tv[1]  = '{32'h3F800000, 32'h40400000, Q_THIRD,      4'b0000, 28};
    tv[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b1000, 2};
    tv[3]  = '{32'h80000000, 32'h00000000, 32'h7FC00000, 4'b0100, 2};
    tv[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28};
    tv[5]  = '{32'h00800000, 32'h4F000000, 32'h00000000, 4'b0001, 28};
    tv[6]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28};
    tv[7]  = '{32'h40000000, 32'hC0800000, 32'hBF000000, 4'b0000, 28};
    tv[8]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 2};
    tv[9]  = '{32'h00000000, 32'h40A00000, 32'h00000000, 4'b0000, 2};
    tv[10] = '{32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000, 2};
    tv[11] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0100, 2};
    tv[12] = '{32'hFF800000, 32'h7F800000, 32'h7FC00000, 4'b0100, 2};
    tv[13] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28};
    tv[14] = '{32'h3F800000, 32'h3F7FFFFF, Q_NEAR1,      4'b0000, 28};
    tv[15] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 2};

    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("reset quotient", bus.quotient, 32'd0);
    chk("reset busy/done", 32'({bus.busy, bus.done}), 32'd0);
    chk("reset flags", 32'(flags()), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      run_op(tv[i].a, tv[i].b, tv[i].q, tv[i].f, tv[i].lat, 0, $sformatf("vec%0d", i));

    // Stray start (1/0) at cycle 10 must not disturb the running 6/2.
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 10, "busy-ignore");
    // Flag set, then a fresh start must clear it by the next cycle.
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b1000, 2, 0, "dbz");
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 0, "after-dbz");
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b1000, 2, 0, "dbz2");

    // Reset in the middle of a division aborts with no done pulse.
    @(negedge clk);
    bus.a = 32'h40C00000; bus.b = 32'h40000000; bus.start = 1'b1;
    saw = 0;
    for (int n = 1; n < 15; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) saw = 1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-reset quotient", bus.quotient, 32'd0);
    chk("mid-reset busy/done", 32'({bus.busy, bus.done}), 32'd0);
    chk("mid-reset flags", 32'(flags()), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) saw = 1;
    end
    chk("no done after abort", 32'(saw), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 0, "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
